icache_controller: RTL and testbench

Direct-mapped instruction cache controller between the CPU fetch port and the 16-byte-block instruction memory. It serves 32-bit instruction words to the CPU from 8 cached blocks and stalls the CPU with `busywait` on a miss. On a miss it runs a block-fetch handshake with the instruction memory (6-bit block address, 128-bit block, memory `busywait`) and refills the line. It also keeps saturating hit/miss counters for performance measurement.

---
 rtl/icache_controller.sv | 129 ++++++++++++
 tb/tb_icache_controller.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/icache_controller.sv
// rtl/icache_controller.sv - direct-mapped 8-line instruction cache controller with hit/miss counters
module icache_controller #(
  parameter int BLOCKS = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [9:0]       address,
  output logic [31:0]      instruction,
  output logic             busywait,
  output logic             mem_read,
  output logic [5:0]       mem_address,
  input  logic [127:0]     mem_readinst,
  input  logic             mem_busywait,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [127:0]      data_q  [BLOCKS];
  logic [2:0]        tag_q   [BLOCKS];
  logic [BLOCKS-1:0] valid_q;

  logic [2:0] miss_tag_q;
  logic [2:0] miss_idx_q;
  logic [CNT_W-1:0] hit_count_q;
  logic [CNT_W-1:0] miss_count_q;

  logic [2:0] cur_tag;
  logic [2:0] cur_idx;
  logic [1:0] cur_word;
  logic       hit;
  logic       miss_start;
  logic       refill;
  logic       unused_byte_sel;

  assign cur_tag  = address[9:7];
  assign cur_idx  = address[6:4];
  assign cur_word = address[3:2];
  // Byte offset within the word is irrelevant to word-aligned fetches.
  assign unused_byte_sel = &address[1:0];

  assign hit = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);

  // The read request is active exactly while the FSM sits in MEM_READ, so it
  // comes straight off the state register and drops on the edge that leaves.
  assign mem_read    = (state_q == MEM_READ);
  assign mem_address = {miss_tag_q, miss_idx_q};
  assign hit_count   = hit_count_q;
  assign miss_count  = miss_count_q;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode, CPU stall and selected instruction word.
  always_comb begin
    state_d     = state_q;
    busywait    = 1'b1;
    miss_start  = 1'b0;
    refill      = 1'b0;
    instruction = data_q[cur_idx][{cur_word, 5'b0} +: 32];
    case (state_q)
      IDLE: begin
        busywait = !hit;
        if (!hit) begin
          miss_start = 1'b1;
          state_d    = MEM_READ;
        end
      end
      MEM_READ: begin
        if (!mem_busywait) begin
          refill  = 1'b1;
          state_d = UPDATE;
        end
      end
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Miss address capture; the refill uses these even if the CPU address moves.
  always_ff @(posedge clock) begin
    if (reset) begin
      miss_tag_q <= 3'd0;
      miss_idx_q <= 3'd0;
    end else if (miss_start) begin
      miss_tag_q <= cur_tag;
      miss_idx_q <= cur_idx;
    end
  end

  // Valid bits are the only line state cleared by reset; reset also aborts a refill.
  always_ff @(posedge clock) begin
    if (reset)       valid_q             <= '0;
    else if (refill) valid_q[miss_idx_q] <= 1'b1;
  end

  // Data and tag arrays carry no reset; valid alone qualifies them.
  always_ff @(posedge clock) begin
    if (refill && !reset) begin
      data_q[miss_idx_q] <= mem_readinst;
      tag_q[miss_idx_q]  <= miss_tag_q;
    end
  end

  // Saturating performance counters: hits per IDLE hit edge, misses per miss entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if ((state_q == IDLE) && hit && (hit_count_q != {CNT_W{1'b1}}))
        hit_count_q <= hit_count_q + 1'b1;
      if (miss_start && (miss_count_q != {CNT_W{1'b1}}))
        miss_count_q <= miss_count_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_icache_controller.sv
// tb/tb_icache_controller.sv - directed self-checking bench for icache_controller
module tb_icache_controller;

  logic         clock;
  logic         reset;
  logic [9:0]   address;
  logic [127:0] mem_readinst;
  logic         mem_busywait;

  logic [31:0]  instruction,  instruction4;
  logic         busywait,     busywait4;
  logic         mem_read,     mem_read4;
  logic [5:0]   mem_address,  mem_address4;
  logic [15:0]  hit_count,    miss_count;
  logic [3:0]   hit_count4,   miss_count4;

  int n_cmp;
  int n_err;

  localparam logic [127:0] BLK0 = {32'hDEADBEEF, 32'h02060405, 32'h00050023, 32'h00040019};
  localparam logic [127:0] BLK1 = {32'h13131313, 32'h12121212, 32'h11111111, 32'h10101010};
  localparam logic [127:0] BLK7 = {32'hCAFEF00D, 32'h77777777, 32'h76767676, 32'h75757575};
  localparam logic [127:0] BLK2 = {32'h2B2B2B2B, 32'h2A2A2A2A, 32'h29292929, 32'h28282828};
  localparam logic [127:0] JUNK = {4{32'hBAADBAAD}};

  icache_controller #(.BLOCKS(8), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .address(address),
    .instruction(instruction), .busywait(busywait),
    .mem_read(mem_read), .mem_address(mem_address),
    .mem_readinst(mem_readinst), .mem_busywait(mem_busywait),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  icache_controller #(.BLOCKS(8), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .address(address),
    .instruction(instruction4), .busywait(busywait4),
    .mem_read(mem_read4), .mem_address(mem_address4),
    .mem_readinst(mem_readinst), .mem_busywait(mem_busywait),
    .hit_count(hit_count4), .miss_count(miss_count4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts at a negedge with the cache in IDLE; returns at the negedge of the
  // IDLE cycle that hits on the freshly filled line.
  task automatic fetch_body(input logic [9:0] a, input logic [127:0] blk, input int lat,
                            input logic [5:0] exp_maddr, input logic [31:0] exp_instr);
    address = a;
    mem_busywait = 1'b0;
    #1;
    check("miss_busy", busywait, 1'b1);
    check("miss_no_read", mem_read, 1'b0);
    @(negedge clock);
    mem_busywait = 1'b1;
    #1;
    check("mread_req", mem_read, 1'b1);
    check("mread_addr", mem_address, exp_maddr);
    check("mread_busy", busywait, 1'b1);
    for (int i = 0; i < lat; i++) begin
      @(negedge clock);
      #1;
      check("mread_hold", {mem_read, mem_address}, {1'b1, exp_maddr});
    end
    @(negedge clock);
    mem_readinst = blk;
    mem_busywait = 1'b0;
    @(negedge clock);
    #1;
    check("upd_read_low", mem_read, 1'b0);
    check("upd_busy", busywait, 1'b1);
    @(negedge clock);
    #1;
    check("refill_hit", busywait, 1'b0);
    check("refill_instr", instruction, exp_instr);
  endtask

  task automatic fetch_miss(input logic [9:0] a, input logic [127:0] blk, input int lat,
                            input logic [5:0] exp_maddr, input logic [31:0] exp_instr);
    @(negedge clock);
    fetch_body(a, blk, lat, exp_maddr, exp_instr);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    address = 10'h000;
    mem_readinst = '0;
    mem_busywait = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_addr", mem_address, 6'h00);
    check("rst_hits", hit_count, 16'd0);
    check("rst_misses", miss_count, 16'd0);

    // Cold fetch of address 0.
    fetch_body(10'h000, BLK0, 2, 6'h00, 32'h00040019);
    check("cold_misses", miss_count, 16'd1);
    check("cold_hits", hit_count, 16'd0);

    // Same-block hits at 4 and 8.
    @(negedge clock);
    address = 10'h004;
    #1;
    check("hit4_busy", busywait, 1'b0);
    check("hit4_instr", instruction, 32'h00040019 ^ 32'h00040019 ^ 32'h00050023);
    check("hit4_no_read", mem_read, 1'b0);
    check("hit4_count", hit_count, 16'd1);
    @(negedge clock);
    address = 10'h008;
    #1;
    check("hit8_instr", instruction, 32'h02060405);
    check("hit8_count", hit_count, 16'd2);
    @(negedge clock);
    #1;
    check("hit8_count2", hit_count, 16'd3);

    // Conflict misses on index 0.
    fetch_miss(10'h080, BLK1, 1, 6'h08, 32'h10101010);
    check("conf1_misses", miss_count, 16'd2);
    check("conf1_hits", hit_count, 16'd4);
    fetch_miss(10'h000, BLK0, 0, 6'h00, 32'h00040019);
    check("conf2_misses", miss_count, 16'd3);
    check("conf2_hits", hit_count, 16'd5);

    // Top block: idx 7, tag 7, word 3.
    fetch_miss(10'h3FC, BLK7, 1, 6'h3F, 32'hCAFEF00D);
    check("top_misses", miss_count, 16'd4);
    @(negedge clock);
    address = 10'h3F0;
    #1;
    check("top_w0_hit", {busywait, instruction}, {1'b0, 32'h75757575});

    // Reset during MEM_READ aborts the refill of idx 0 tag 2.
    @(negedge clock);
    address = 10'h100;
    #1;
    check("rmid_busy", busywait, 1'b1);
    @(negedge clock);
    mem_busywait = 1'b1;
    #1;
    check("rmid_req", {mem_read, mem_address}, {1'b1, 6'h10});
    reset = 1'b1;
    mem_busywait = 1'b0;
    mem_readinst = JUNK;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rmid_read_low", mem_read, 1'b0);
    check("rmid_not_valid", busywait, 1'b1);
    check("rmid_hits", hit_count, 16'd0);
    check("rmid_misses", miss_count, 16'd0);
    fetch_body(10'h100, BLK2, 1, 6'h10, 32'h28282828);
    check("rmid_refetch_misses", miss_count, 16'd1);

    // Saturation: 20 consecutive hits on the refilled line.
    address = 10'h10C;
    repeat (20) @(negedge clock);
    #1;
    check("sat_instr", instruction, 32'h2B2B2B2B);
    check("sat_hits16", hit_count, 16'd20);
    check("sat_hits4", hit_count4, 4'd15);
    repeat (3) @(negedge clock);
    #1;
    check("sat_hold4", hit_count4, 4'd15);
    check("sat_misses4", miss_count4, 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
